// File: rtl/des_dec_key_schedule.sv
// -----------------------------------------------------------------------------
// des_dec_key_schedule
//
// Purpose:
//   Sequential DES key schedule for decryption. It loads a 64-bit key and then
//   issues the 16 round subkeys in reverse order. K16 is issued first and K1
//   last. The block advances by one subkey for each valid/ready handshake.
//   Bit numbering follows FIPS 46-3, where bit 1 is the MSB: i_Key[63] is key
//   bit 1 and o_Subkey[47] is subkey bit 1.
//
// Ports:
//   i_Clk      rising-edge clock
//   i_Rst_n    asynchronous active-low reset
//   i_Start    begin a schedule with i_Key (accepted only when idle)
//   i_Key      64-bit DES key; the parity bits 8,16,..,64 are ignored
//   i_Clear    synchronous abort back to idle; wins over i_Start and i_Ready
//   i_Ready    consumer accepts the current subkey
//   o_Subkey   48-bit subkey for the current decryption round
//   o_Valid    o_Subkey / o_Round are valid
//   o_Round    decryption round index 0..15 (0 carries K16, 15 carries K1)
//   o_Busy     a schedule is in progress
//   o_Done     one-cycle pulse after the 16th subkey is accepted
// -----------------------------------------------------------------------------
module des_dec_key_schedule #(
  // Fixed by DES; not meant to be overridden.
  parameter int NUM_ROUNDS = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  input  logic [63:0] i_Key,
  input  logic        i_Clear,
  input  logic        i_Ready,
  output logic [47:0] o_Subkey,
  output logic        o_Valid,
  output logic [3:0]  o_Round,
  output logic        o_Busy,
  output logic        o_Done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  // Bit r is set when the right rotation into destination round r is 2.
  // Otherwise the rotation is 1. Round 0 is never rotated into: it is loaded.
  // The amounts by round are 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  localparam logic [15:0] ROT2_MASK = 16'h7EFC;

  // PC-1 table: source key bit numbers (1 = MSB) for C1..C28, then D1..D28.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2 table: source bit numbers in the 56-bit {C,D} word (1 = MSB).
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [27:0] c_reg, c_next;
  logic [27:0] d_reg, d_next;
  logic [3:0]  round_reg, round_next;
  logic        done_reg, done_next;

  logic [55:0] pc1_cd;
  logic [55:0] cd;
  logic [47:0] pc2_key;
  logic [3:0]  round_inc;
  logic        rot_two;

  // The parity bits have no function in DES.
  logic        key_parity_unused;
  assign key_parity_unused = ^{i_Key[56], i_Key[48], i_Key[40], i_Key[32],
                               i_Key[24], i_Key[16], i_Key[8],  i_Key[0]};

  // Convert the 1-based MSB-first table entries into vector indices.
  for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
    assign pc1_cd[55 - gi] = i_Key[64 - PC1[gi]];
  end

  assign cd = {c_reg, d_reg};

  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign pc2_key[47 - gi] = cd[56 - PC2[gi]];
  end

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign round_inc = round_reg + 4'd1;
  assign rot_two   = ROT2_MASK[round_inc];

  // State register and schedule registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      round_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      round_reg <= round_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic and datapath updates.
  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    round_next = round_reg;
    done_next  = 1'b0;

    if (i_Clear) begin
      // Abort silently. C/D are left as they are because the next start
      // reloads them.
      state_next = IDLE;
      round_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_Start) begin
            // Encryption rotates left by 28 in total, which is the identity.
            // So K16 comes straight from the PC-1 output.
            c_next     = pc1_cd[55:28];
            d_next     = pc1_cd[27:0];
            round_next = '0;
            state_next = ROUND;
          end
        end
        ROUND: begin
          if (i_Ready) begin
            if (round_reg == LAST_ROUND) begin
              state_next = IDLE;
              round_next = '0;
              done_next  = 1'b1;
            end else begin
              round_next = round_inc;
              c_next     = ror28(c_reg, rot_two);
              d_next     = ror28(d_reg, rot_two);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign o_Valid  = (state_reg == ROUND);
  assign o_Busy   = (state_reg != IDLE);
  assign o_Round  = round_reg;
  assign o_Done   = done_reg;
  // Outputs are gated so that idle subkeys read as zero rather than stale data.
  assign o_Subkey = o_Valid ? pc2_key : '0;

endmodule

// File: tb/tb_des_dec_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_dec_key_schedule
//
// Purpose:
//   Self-checking bench for des_dec_key_schedule.
//   Stimulus pushes the expected {round, subkey} pairs into a queue.
//   A negedge monitor pops an entry and compares it on every handshake.
//   Directed checks cover reset, latency, backpressure, busy protection,
//   back-to-back operation, clear and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_des_dec_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] key;
  logic        clear;
  logic        ready;
  logic [47:0] subkey;
  logic        valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  des_dec_key_schedule dut (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .i_Start  (start),
    .i_Key    (key),
    .i_Clear  (clear),
    .i_Ready  (ready),
    .o_Subkey (subkey),
    .o_Valid  (valid),
    .o_Round  (round),
    .o_Busy   (busy),
    .o_Done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  // Only the parity bits are set here, so every subkey must be zero.
  localparam logic [63:0] KEYP = 64'h0101010101010101;

  typedef struct packed {
    logic [3:0]  rnd;
    logic [47:0] sk;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] k_enc [16];   // k_enc[i] = K(i+1), the encryption-order subkeys
  int          checks;
  int          errors;
  int          done_seen;
  int          done_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected subkeys for rounds first..first+count-1.
  task automatic push_sched(input logic zero_key, input int first, input int count);
    exp_t e;
    for (int r = first; r < first + count; r++) begin
      e.rnd = 4'(r);
      e.sk  = zero_key ? 48'h0 : k_enc[15 - r];
      exp_q.push_back(e);
    end
  endtask

  // Pulse i_Start and check that o_Valid appears one cycle later.
  task automatic start_sched(input logic [63:0] k);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("latency_valid", 64'(valid), 64'd1);
    chk("latency_round", 64'(round), 64'd0);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(valid && round == r) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("wait_round_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("wait_done_timeout", 64'd1, 64'd0);
    done_exp++;
  endtask

  // Monitor: every handshake pops one expectation, and every done pulse is
  // counted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_handshake", 64'(round), 64'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("hs_round", 64'(round), 64'(e.rnd));
          chk("hs_subkey", 64'(subkey), 64'(e.sk));
          chk("hs_busy", 64'(busy), 64'd1);
          $display("handshake round=%0d subkey=%h expected=%h", round, subkey, e.sk);
        end
      end
      if (done) begin
        done_seen++;
        chk("done_valid_low", 64'(valid), 64'd0);
        $display("done pulse #%0d", done_seen);
      end
    end
  end

  initial begin
    k_enc = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
              48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
              48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
              48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    checks = 0; errors = 0; done_seen = 0; done_exp = 0;
    rst_n = 1'b0; start = 1'b0; key = '0; clear = 1'b0; ready = 1'b0;

    // Reset, then idle.
    step(); step();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    rst_n = 1'b1;
    repeat (10) step();
    chk("idle_valid", 64'(valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Standard vector with ready held high.
    ready = 1'b1;
    push_sched(1'b0, 0, 16);
    start_sched(KEY1);
    chk("first_subkey_k16", 64'(subkey), 64'hCB3D8B0E17F5);
    wait_done();
    chk("done_cycle_valid", 64'(valid), 64'd0);
    step();
    chk("post_done_valid", 64'(valid), 64'd0);
    chk("post_done_pulse", 64'(done), 64'd0);
    chk("post_done_busy", 64'(busy), 64'd0);

    // Parity-only key: every subkey is zero.
    push_sched(1'b1, 0, 16);
    start_sched(KEYP);
    wait_done();
    step();

    // Backpressure at round 3.
    push_sched(1'b0, 0, 16);
    start_sched(KEY1);
    wait_round(4'd3);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_subkey", 64'(subkey), 64'(k_enc[12]));
      chk("bp_round", 64'(round), 64'd3);
      chk("bp_valid", 64'(valid), 64'd1);
    end
    ready = 1'b1;
    wait_done();
    step();

    // Busy protection at round 7, then a back-to-back start in the done cycle.
    push_sched(1'b0, 0, 16);
    start_sched(KEY1);
    wait_round(4'd7);
    key   = KEYP;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_ign_round", 64'(round), 64'd8);
    chk("busy_ign_subkey", 64'(subkey), 64'(k_enc[7]));
    wait_done();
    push_sched(1'b0, 0, 16);
    start_sched(KEY1);
    chk("b2b_subkey_k16", 64'(subkey), 64'hCB3D8B0E17F5);
    wait_done();
    step();

    // Clear at round 5: no done pulse, then a full restart.
    push_sched(1'b0, 0, 5);
    start_sched(KEY1);
    wait_round(4'd5);
    ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_valid", 64'(valid), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_round", 64'(round), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    step();
    chk("clr_no_done", 64'(done), 64'd0);
    ready = 1'b1;
    push_sched(1'b0, 0, 16);
    start_sched(KEY1);
    wait_done();
    step();

    // Asynchronous reset mid-schedule.
    push_sched(1'b0, 0, 3);
    start_sched(KEY1);
    wait_round(4'd3);
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_round", 64'(round), 64'd0);
    chk("arst_subkey", 64'(subkey), 64'd0);
    step(); step();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (3) step();
    chk("arst_idle_valid", 64'(valid), 64'd0);
    chk("arst_idle_busy", 64'(busy), 64'd0);

    repeat (2) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'(done_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
